// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
// Optional overflow output is enabled in serial_add by defining SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_add_fa.sv
// Single-bit full adder used as the arithmetic core of serial_add.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: one bit pair per cycle through fa, LSB first, with registered sum.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow output ovf.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_nx;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .co (fa_co),
    .s  (fa_s)
  );

  // Sum bits enter from the MSB side so bit 0 lands at s[0] after WIDTH shifts.
  assign sum_nx = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    s_d      = s_q;
    co_d     = co_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = ci;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_nx;
        carry_d  = fa_co;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          s_d     = sum_nx;
          co_d    = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB while the MSB is being added.
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      s_q      <= '0;
      co_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      co_q     <= co_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
